// File: rtl/tree_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tree_walker
//  Purpose  : Walks one decision tree held in an external node ROM. Holds a
//             16-entry feature vector, issues ROM addresses from the root,
//             evaluates each returned node and reports the leaf class.
//  Ports    : clk, rst_n              - clock, synchronous active-low reset
//             feat_we/addr/wdata      - feature register write (IDLE only)
//             start                   - launch a traversal (level sampled)
//             rom_addr / node_data    - ROM address out, ROM word back
//                                       (data valid one cycle after address)
//             busy, done              - walk in progress / 1-cycle result
//             class_out, err, depth   - leaf class, abort flag, nodes walked
//  Revision : 1.0 - initial release
// ============================================================================
module tree_walker #(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int FEAT_WIDTH = 64,
    parameter int NUM_FEAT   = 16,
    parameter int ROOT_ADDR  = 0,
    parameter int MAX_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  feat_we,
    input  logic [3:0]            feat_addr,
    input  logic [FEAT_WIDTH-1:0] feat_wdata,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [NODE_WIDTH-1:0] node_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            class_out,
    output logic                  err,
    output logic [5:0]            depth
);

    localparam int                  c_ID_W     = 12;
    localparam int                  c_CMP_W    = (ADDR_WIDTH > c_ID_W) ? ADDR_WIDTH : c_ID_W;
    localparam logic [ADDR_WIDTH-1:0] c_ROOT   = ADDR_WIDTH'(ROOT_ADDR);
    localparam logic [5:0]          c_MAX_DEPTH = 6'(MAX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    state_t                r_state;
    logic [FEAT_WIDTH-1:0] r_feat [NUM_FEAT];

    // Node word fields
    logic [c_ID_W-1:0]     w_node_id;
    logic [3:0]            w_feat_idx;
    logic [FEAT_WIDTH-1:0] w_thr;
    logic [c_ID_W-1:0]     w_left;
    logic [c_ID_W-1:0]     w_right;
    logic [3:0]            w_tag;
    logic                  w_is_leaf;
    logic                  w_id_bad;
    logic                  w_go_left;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_unused;

    assign w_node_id  = node_data[107:96];
    assign w_feat_idx = node_data[95:92];
    assign w_thr      = node_data[28 +: FEAT_WIDTH];
    assign w_left     = node_data[27:16];
    assign w_right    = node_data[15:4];
    assign w_tag      = node_data[3:0];
    assign w_unused   = ^node_data[NODE_WIDTH-1:108];

    // Leaf detection uses the full child fields, before truncation.
    assign w_is_leaf  = (w_left == '0) && (w_right == '0);
    assign w_id_bad   = c_CMP_W'(w_node_id) != c_CMP_W'(rom_addr);

    // Sign-magnitude (a <= b) on raw double bit patterns; +0 and -0 are equal.
    function automatic logic f_dbl_le(input logic [FEAT_WIDTH-1:0] a,
                                      input logic [FEAT_WIDTH-1:0] b);
        logic [FEAT_WIDTH-2:0] ma;
        logic [FEAT_WIDTH-2:0] mb;
        logic                  res;
        ma = a[FEAT_WIDTH-2:0];
        mb = b[FEAT_WIDTH-2:0];
        if (ma == '0 && mb == '0)
            res = 1'b1;
        else if (a[FEAT_WIDTH-1] != b[FEAT_WIDTH-1])
            res = a[FEAT_WIDTH-1];
        else if (!a[FEAT_WIDTH-1])
            res = (ma <= mb);
        else
            res = (ma >= mb);
        return res;
    endfunction

    assign w_go_left   = f_dbl_le(r_feat[w_feat_idx], w_thr);
    assign w_next_addr = w_go_left ? ADDR_WIDTH'(w_left) : ADDR_WIDTH'(w_right);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            rom_addr  <= c_ROOT;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= 4'd0;
            err       <= 1'b0;
            depth     <= 6'd0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                r_feat[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The walk reads features only from EVAL onward, so a
                    // write in the same cycle as start is already visible.
                    if (feat_we) begin
                        r_feat[feat_addr] <= feat_wdata;
                    end
                    if (start) begin
                        rom_addr <= c_ROOT;
                        busy     <= 1'b1;
                        depth    <= 6'd0;
                        err      <= 1'b0;
                        r_state  <= S_WAIT;
                    end
                end
                // ROM output register captures the addressed word here.
                S_WAIT: r_state <= S_EVAL;
                S_EVAL: begin
                    if (w_id_bad || (!w_is_leaf && depth == c_MAX_DEPTH)) begin
                        err       <= 1'b1;
                        class_out <= 4'd0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_is_leaf) begin
                        class_out <= w_tag;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        rom_addr <= w_next_addr;
                        depth    <= depth + 6'd1;
                        r_state  <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tree_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tree_walker
//  Purpose  : Self-checking bench for tree_walker. A registered ROM model
//             feeds the DUT; expected results come from a reference walk
//             that compares features as real numbers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tree_walker;

    localparam int AW   = 10;
    localparam int NW   = 120;
    localparam int MAXD = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          feat_we;
    logic [3:0]    feat_addr;
    logic [63:0]   feat_wdata;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [NW-1:0] node_data;
    logic          busy;
    logic          done;
    logic [3:0]    class_out;
    logic          err;
    logic [5:0]    depth;

    logic [NW-1:0] rom [1024];
    logic [63:0]   fm  [16];
    int            n_assert = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) node_data <= rom[rom_addr];

    tree_walker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_we    (feat_we),
        .feat_addr  (feat_addr),
        .feat_wdata (feat_wdata),
        .start      (start),
        .rom_addr   (rom_addr),
        .node_data  (node_data),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out),
        .err        (err),
        .depth      (depth)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] mk_node(input int id, input int idx, input logic [63:0] thr,
                                              input int l, input int r, input int tag);
        logic [NW-1:0] w;
        w = '0;
        w[107:96] = id[11:0];
        w[95:92]  = idx[3:0];
        w[91:28]  = thr;
        w[27:16]  = l[11:0];
        w[15:4]   = r[11:0];
        w[3:0]    = tag[3:0];
        return w;
    endfunction

    function automatic logic dle(input logic [63:0] a, input logic [63:0] b);
        return $bitstoreal(a) <= $bitstoreal(b);
    endfunction

    // Reference traversal straight from the node-format rules.
    task automatic model(output logic [3:0] cls, output logic er, output int dep, output int nodes);
        int            a;
        logic [NW-1:0] w;
        a = 0; dep = 0; nodes = 0; cls = 4'd0; er = 1'b0;
        for (int g = 0; g < 100; g++) begin
            nodes++;
            w = rom[a];
            if (int'(w[107:96]) != a) begin er = 1'b1; return; end
            if (w[27:16] == 12'd0 && w[15:4] == 12'd0) begin cls = w[3:0]; return; end
            if (dep == MAXD) begin er = 1'b1; return; end
            a = dle(fm[w[95:92]], w[91:28]) ? int'(w[27:16]) % 1024 : int'(w[15:4]) % 1024;
            dep++;
        end
    endtask

    function automatic logic [63:0] rnd_dbl();
        logic [63:0] v;
        case ($urandom % 8)
            0:       v = 64'h0;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = {1'($urandom), 11'($urandom_range(0, 2046)), 32'($urandom), 20'($urandom)};
            default: v = {1'($urandom), 11'($urandom_range(1016, 1032)), 4'($urandom), 48'h0};
        endcase
        return v;
    endfunction

    task automatic write_feat(input int a, input logic [63:0] v);
        @(negedge clk);
        feat_we = 1'b1; feat_addr = a[3:0]; feat_wdata = v;
        @(negedge clk);
        feat_we = 1'b0;
        fm[a] = v;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = mk_node(i, 0, 64'h0, 0, 0, 0);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) check({tag, ".timeout"}, 64'(done), 64'd1);
    endtask

    // One traversal; optionally a feature write in the start cycle, and a
    // dropped write / ignored start injected while busy.
    task automatic run_walk(input string tag, input bit wr, input int wa, input logic [63:0] wd,
                            input bit inj_we, input bit inj_start);
        logic [3:0] ecls;
        logic       eerr;
        int         edep, enodes, cyc, ndone;
        if (wr) fm[wa] = wd;
        model(ecls, eerr, edep, enodes);
        @(negedge clk);
        start = 1'b1;
        if (wr) begin feat_we = 1'b1; feat_addr = wa[3:0]; feat_wdata = wd; end
        @(negedge clk);
        start = 1'b0; feat_we = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (inj_we)    begin feat_we = 1'b1; feat_addr = 4'(wa); feat_wdata = ~fm[wa]; end
                if (inj_start) start = 1'b1;
            end else begin
                feat_we = 1'b0;
                start   = 1'b0;
            end
        end
        feat_we = 1'b0; start = 1'b0;
        check({tag, ".latency"}, 64'(cyc), 64'(2 * enodes));
        check({tag, ".class"},   64'(class_out), 64'(ecls));
        check({tag, ".err"},     64'(err), 64'(eerr));
        check({tag, ".depth"},   64'(depth), 64'(edep));
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check({tag, ".extra_done"}, 64'(ndone), 64'd0);
        check({tag, ".class_hold"}, 64'(class_out), 64'(ecls));
    endtask

    task automatic build_random_rom();
        for (int i = 0; i < 1024; i++) begin
            int l, r;
            if (i > 1000 || ($urandom % 4) == 0) begin
                rom[i] = mk_node(i, 0, 64'h0, 0, 0, int'($urandom % 16));
            end else begin
                l = i + 1 + int'($urandom % 8);
                r = i + 1 + int'($urandom % 8);
                if (l > 1023) l = 1023;
                if (r > 1023) r = 1023;
                // Random bits above the address width exercise truncation.
                l = l + 1024 * int'($urandom % 4);
                r = r + 1024 * int'($urandom % 4);
                rom[i] = mk_node(i, int'($urandom % 16), rnd_dbl(), l, r, int'($urandom % 16));
            end
            if (($urandom % 64) == 0) rom[i][107:96] = rom[i][107:96] ^ 12'h001;
        end
    endtask

    initial begin
        int cyc, nd;
        rst_n = 1'b0; feat_we = 1'b0; feat_addr = 4'd0; feat_wdata = 64'h0; start = 1'b0;
        for (int i = 0; i < 16; i++) fm[i] = 64'h0;
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst.busy",  64'(busy), 64'd0);
        check("rst.done",  64'(done), 64'd0);
        check("rst.class", 64'(class_out), 64'd0);
        check("rst.err",   64'(err), 64'd0);
        check("rst.depth", 64'(depth), 64'd0);
        check("rst.addr",  64'(rom_addr), 64'd0);
        rst_n = 1'b1;

        // Directed tree
        rom[0]     = mk_node(0,     0, 64'h41D0_0000_0000_0000, 1,     'hA0, 0);
        rom[1]     = mk_node(1,     1, 64'h4068_1000_0000_0000, 2,     3,    0);
        rom[2]     = mk_node(2,     0, 64'h0, 0, 0, 1);
        rom[3]     = mk_node(3,     0, 64'h0, 0, 0, 5);
        rom['hA0]  = mk_node('hA0, 10, 64'h0,                   'hC2,  3,    0);
        rom['hC2]  = mk_node('hC2,  2, 64'h8000_0000_0000_0000, 'hC3,  3,    0);
        rom['hC3]  = mk_node('hC3,  3, 64'h3FF0_0000_0000_0000, 'hCD,  3,    0);
        rom['hCD]  = mk_node('hCD,  0, 64'h0, 0, 0, 0);

        write_feat(0, 64'h41D0_0000_0000_0000);
        write_feat(1, 64'h4060_0000_0000_0000);
        run_walk("path012", 0, 0, 64'h0, 0, 0);
        check("path012.class1", 64'(class_out), 64'd1);
        check("path012.depth2", 64'(depth), 64'd2);

        write_feat(1, 64'h4068_1000_0000_0000);
        run_walk("equal", 0, 0, 64'h0, 0, 0);
        check("equal.class1", 64'(class_out), 64'd1);

        write_feat(1, 64'hC000_0000_0000_0000);
        run_walk("negpos", 0, 0, 64'h0, 0, 0);
        check("negpos.class1", 64'(class_out), 64'd1);

        write_feat(1, 64'h4070_0000_0000_0000);
        run_walk("right", 0, 0, 64'h0, 0, 0);
        check("right.class5", 64'(class_out), 64'd5);

        write_feat(0, 64'h41E0_0000_0000_0000);
        write_feat(1, 64'h0);
        run_walk("deep", 0, 0, 64'h0, 0, 0);
        check("deep.class0", 64'(class_out), 64'd0);
        check("deep.depth4", 64'(depth), 64'd4);

        write_feat(2, 64'h8000_0000_0000_0000);
        run_walk("negzero", 0, 0, 64'h0, 0, 0);

        run_walk("wr_start", 1, 0, 64'h41D0_0000_0000_0000, 0, 0);
        check("wr_start.class1", 64'(class_out), 64'd1);

        run_walk("busy_we",    0, 0, 64'h0, 1, 0);
        run_walk("rerun",      0, 0, 64'h0, 0, 0);
        run_walk("busy_start", 0, 0, 64'h0, 0, 1);

        // start held high relaunches right after done
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done("held1", cyc);
        @(negedge clk);
        check("held.relaunch", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done("held2", cyc);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("held.extra_done", 64'(nd), 64'd0);

        // Bad node_id at the root
        rom[0] = mk_node(5, 0, 64'h0, 1, 2, 0);
        run_walk("bad_id", 0, 0, 64'h0, 0, 0);
        check("bad_id.err", 64'(err), 64'd1);

        // Self-loop at the root hits the depth limit
        rom[0] = mk_node(0, 0, 64'h7FF0_0000_0000_0000, 0, 5, 3);
        run_walk("loop", 0, 0, 64'h0, 0, 0);
        check("loop.err",   64'(err), 64'd1);
        check("loop.depth", 64'(depth), 64'd32);

        // Random trees and feature vectors
        for (int t = 0; t < 10; t++) begin
            build_random_rom();
            for (int f = 0; f < 16; f++) write_feat(f, rnd_dbl());
            run_walk($sformatf("rand%0d", t), 0, 0, 64'h0, 0, 0);
        end

        // Reset during WAIT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.busy",  64'(busy), 64'd0);
        check("midrst.done",  64'(done), 64'd0);
        check("midrst.class", 64'(class_out), 64'd0);
        check("midrst.err",   64'(err), 64'd0);
        check("midrst.depth", 64'(depth), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) fm[i] = 64'h0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("midrst.no_done", 64'(nd), 64'd0);
        run_walk("after_rst", 0, 0, 64'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tree_walker.md
Name: tree_walker

Overview:
- Traversal engine directly downstream of the per-tree node ROMs (tree_rom_0..N).
- Holds a 16-entry feature vector, walks one decision tree from the root by issuing ROM addresses and evaluating each returned node, and reports the leaf class.
- One instance per tree ROM; results feed the ensemble voting stage.

Parameters:
- NODE_WIDTH, 120, width of ROM node word.
- ADDR_WIDTH, 10, ROM address width.
- FEAT_WIDTH, 64, feature/threshold width (IEEE-754 double bit pattern).
- NUM_FEAT, 16, feature register count (index field is 4 bits).
- ROOT_ADDR, 0, root node address.
- MAX_DEPTH, 32, maximum internal nodes evaluated before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- feat_we  in  1  feature write strobe
- feat_addr  in  4  feature index to write
- feat_wdata  in  64  feature value (double)
- start  in  1  begin traversal (level-sampled)
- rom_addr  out  ADDR_WIDTH  address to tree ROM (registered)
- node_data  in  NODE_WIDTH  ROM read data, valid 1 cycle after rom_addr
- busy  out  1  traversal in progress
- done  out  1  one-cycle pulse: result valid
- class_out  out  4  leaf class, held until next start
- err  out  1  traversal aborted, held with class_out
- depth  out  6  internal nodes evaluated in last/current walk

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous, active-low.
  - In reset: state=IDLE, rom_addr=ROOT_ADDR, busy=0, done=0, class_out=0, err=0, depth=0, all feature regs=0.
  - Reset mid-walk aborts the walk with no done pulse.
- Node word decode (bits above 107 ignored):
  - [107:96] node_id
  - [95:92] feat_idx
  - [91:28] threshold
  - [27:16] left child
  - [15:4] right child
  - [3:0] tag
  - Leaf iff left==0 && right==0 (root is never a child). Leaf class = tag.
  - Children are truncated to ADDR_WIDTH.
- Feature writes:
  - Accepted only in IDLE: feat[feat_addr] <= feat_wdata.
  - Writes while busy are dropped.
  - Write and start in the same IDLE cycle: the write lands first, and the walk uses the new value.
- FSM IDLE / WAIT / EVAL:
  - IDLE & start: rom_addr<=ROOT_ADDR, busy<=1, depth<=0, err<=0, -> WAIT.
  - WAIT: -> EVAL (ROM output register updates on this edge).
  - EVAL, node_id != rom_addr (zero-extended): err<=1, class_out<=0, done<=1, -> IDLE.
  - EVAL, leaf: class_out<=tag, done<=1, -> IDLE.
  - EVAL, internal with depth==MAX_DEPTH: err<=1, class_out<=0, done<=1, -> IDLE.
  - EVAL, internal otherwise: rom_addr <= (feat[feat_idx] <= threshold) ? left : right; depth++; -> WAIT.
  - busy clears in the same edge done asserts; done is low in every other cycle.
  - start while busy is ignored. start held high re-launches in the cycle after done.
- Latency: a path of k nodes (leaf included) gives done 2k cycles after the start edge.
- Compare (a <= b) on doubles, sign-magnitude:
  - Both magnitudes ([62:0]) zero -> true.
  - Signs differ -> true iff a negative.
  - Both positive -> a[62:0] <= b[62:0].
  - Both negative -> a[62:0] >= b[62:0].
  - No NaN handling; raw bit patterns are compared.

Test Plan:
- tree_rom_7 as ROM; feat0=0x41D0000000000000, feat1=0x4060000000000000, start -> path 0,1,2; done 6 cycles after start; class_out=1, err=0, depth=2.
- feat0=0x41E0000000000000, feat10=0, others 0 -> path 0,0xA0,0xC2,0xC3,0xCD; done at +10; class_out=0, depth=4.
- Equality: feat1 = 0x4068100000000000 (equals node-1 threshold) with the first test's feat0 -> goes left, class_out=1. Also negative-vs-positive and -0 vs +0 compares go left.
- Stub ROM returning node_id != address at root -> done at +2, err=1, class_out=0. Stub self-loop internal node -> err=1 after MAX_DEPTH evaluations, depth=32.
- feat_we pulsed while busy, then rerun -> result unchanged. start pulsed while busy -> ignored, exactly one done.
- rst_n low during WAIT -> next cycle busy=0, no done, class_out=0, features cleared. Subsequent walk with all-zero features matches the reference-model class.
